ram_sync_rd_client: RTL
=======================

# ram_sync_rd_client

Request-side controller that sits in front of a synchronous 1-read/1-write RAM with one-cycle registered read latency and no flow control of its own. It gives the rest of the core independent ready/valid write and read request channels and a ready/valid read-response channel. It handles the RAM's fixed read latency, buffers responses under backpressure, and forwards same-cycle write data so reads never return stale data. Typical users are a load/store unit or an instruction fetch stage.

## Interface
- width_p, 8, data word width in bits
- depth_p, 512, RAM depth in words; address width aw = $clog2(depth_p)

Reset is asynchronous and active-low. The block has one clock.

- clk_i  in  1  clock; all state updates on the rising edge
- reset_ni  in  1  asynchronous active-low reset
- wr_valid_i  in  1  write request valid
- wr_ready_o  out  1  write request ready
- wr_addr_i  in  aw  write address
- wr_data_i  in  width_p  write data
- rd_valid_i  in  1  read request valid
- rd_ready_o  out  1  read request ready
- rd_addr_i  in  aw  read address
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  read response accepted by consumer
- rsp_data_o  out  width_p  read response data
- ram_wr_valid_o  out  1  RAM write enable
- ram_wr_addr_o  out  aw  RAM write address
- ram_wr_data_o  out  width_p  RAM write data
- ram_rd_valid_o  out  1  RAM read enable
- ram_rd_addr_o  out  aw  RAM read address
- ram_rd_data_i  in  width_p  RAM registered read data; valid the cycle after ram_rd_valid_o

## Operation
- **Startup flop:** up_q is cleared by reset and set on the first clock edge after reset_ni deasserts. Both ready outputs are gated by up_q.
- **Writes:**
  - wr_ready_o = up_q.
  - ram_wr_valid_o = wr_valid_i & wr_ready_o.
  - ram_wr_addr_o and ram_wr_data_o pass straight through from wr_addr_i and wr_data_i.
  - Writes take one cycle, produce no response, and are never stalled.
- **Reads:**
  - rd_ready_o = up_q & ((count_q + inflight_q < 2) | (rsp_valid_o & rsp_ready_i)).
  - count_q is the response buffer occupancy, 0..2. inflight_q is 1 if a read was issued last cycle.
  - ram_rd_valid_o = rd_valid_i & rd_ready_o. ram_rd_addr_o = rd_addr_i.
- **Forwarding:**
  - Condition: a read issues in the same cycle as an accepted write to the same address.
  - Effect: fwd_q is set and fwd_data_q captures wr_data_i.
  - The RAM returns old data in this case. The block must return the new data.
- **Capture:**
  - In the cycle with inflight_q = 1, the block pushes fwd_q ? fwd_data_q : ram_rd_data_i into the 2-entry response FIFO.
  - The same cycle's pop, if any, is applied simultaneously.
- **Response buffer:**
  - 2-entry circular FIFO with 1-bit read and write pointers that wrap.
  - rsp_valid_o = (count_q != 0). rsp_data_o = head entry, registered.
  - Pop when rsp_valid_o & rsp_ready_i.
  - Simultaneous push and pop leaves count_q unchanged.
  - Overflow is impossible by construction. An assertion checks count_q ≤ 2.
- **Ordering:**
  - Responses are returned strictly in read-issue order.
  - A write accepted in cycle N is visible to any read issued in cycle N or later.
  - A read issued before the write returns the old data.
- **Combinational path:** there is one, from rsp_ready_i to rd_ready_o. It is required for full throughput.
- **Reset assertion:**
  - Immediately clears up_q, count_q, both pointers, inflight_q and fwd_q.
  - In-flight and buffered responses are discarded and never presented.
  - RAM contents are untouched.
- **Reset values:**
  - 0: wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o, ram_wr_valid_o, ram_rd_valid_o.
  - The ram_* address and data outputs follow their inputs.

## Timing
- **Read latency:** read accepted at edge N produces rsp_valid_o in cycle N+2 at the earliest.
- **Throughput:** sustained one read and one write per cycle while rsp_ready_i = 1.
- **Backpressure:** with rsp_ready_i held at 0, at most two reads are accepted. rd_ready_o falls in the second cycle after the first acceptance.
- **Recovery:** the first cycle rsp_ready_i = 1 reopens rd_ready_o in that same cycle.
- **Post-reset:** both ready outputs are 0 in the first cycle after reset deassertion and 1 from the following cycle.

## Test plan
- **Reset values:** hold reset_ni low, then release. All valid and ready outputs are 0 during reset. wr_ready_o and rd_ready_o go to 1 one cycle after release. rsp_valid_o stays 0.
- **Read after write:** write 0xA5 to addr 3 at cycle N, read addr 3 at N+1. rsp_data_o = 0xA5 with rsp_valid_o high at N+3.
- **Same-cycle forwarding:** addr 7 holds 0x11. In one cycle, write 0x3C to addr 7 and read addr 7. The response is 0x3C. A read of addr 7 issued one cycle earlier returns 0x11.
- **Backpressure:** with rsp_ready_i = 0, present reads of addrs 0, 1, 2 back-to-back. Two are accepted and rd_ready_o drops. Raise rsp_ready_i: the third read is accepted in the same cycle as the first pop. Responses appear as data[0], data[1], data[2] in order.
- **Streaming:** with rsp_ready_i = 1, issue 8 consecutive reads of addrs 0..7. rd_ready_o never drops. Responses arrive on 8 consecutive cycles starting 2 cycles after the first read.
- **Reset mid-operation:** with one read in flight and one buffered, pulse reset_ni low. rsp_valid_o falls asynchronously. After release, no stale response appears, and a subsequent read returns correct data.

Source files
------------

// File: rtl/ram_sync_rd_client.sv
// Ready/valid request front-end for a synchronous 1R1W RAM with one-cycle read latency.
// Returns read data in issue order through a 2-entry buffer and forwards same-cycle writes.
module ram_sync_rd_client #(
  parameter int width_p = 8,
  parameter int depth_p = 512,
  localparam int aw = $clog2(depth_p)
) (
  input  logic               clk_i,
  input  logic               reset_ni,

  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [aw-1:0]      wr_addr_i,
  input  logic [width_p-1:0] wr_data_i,

  input  logic               rd_valid_i,
  output logic               rd_ready_o,
  input  logic [aw-1:0]      rd_addr_i,

  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [width_p-1:0] rsp_data_o,

  output logic               ram_wr_valid_o,
  output logic [aw-1:0]      ram_wr_addr_o,
  output logic [width_p-1:0] ram_wr_data_o,
  output logic               ram_rd_valid_o,
  output logic [aw-1:0]      ram_rd_addr_o,
  input  logic [width_p-1:0] ram_rd_data_i
);

  logic               up_q;
  logic               inflight_q;
  logic               fwd_q;
  logic [width_p-1:0] fwd_data_q;
  logic [1:0]         count_q;
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [width_p-1:0] fifo_q [2];

  logic               wr_fire;
  logic               rd_fire;
  logic               push;
  logic               pop;
  logic [width_p-1:0] push_data;

  assign wr_ready_o     = up_q;
  assign wr_fire        = wr_valid_i & wr_ready_o;
  assign ram_wr_valid_o = wr_fire;
  assign ram_wr_addr_o  = wr_addr_i;
  assign ram_wr_data_o  = wr_data_i;

  assign rsp_valid_o = (count_q != 2'd0);
  assign rsp_data_o  = fifo_q[rd_ptr_q];
  assign pop         = rsp_valid_o & rsp_ready_i;

  // A pop this cycle frees a slot, so rsp_ready_i feeds rd_ready_o directly for full rate.
  assign rd_ready_o = up_q &
                      ((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) | pop);
  assign rd_fire        = rd_valid_i & rd_ready_o;
  assign ram_rd_valid_o = rd_fire;
  assign ram_rd_addr_o  = rd_addr_i;

  // The RAM returns pre-write data on a same-cycle collision, so the captured write wins.
  assign push      = inflight_q;
  assign push_data = fwd_q ? fwd_data_q : ram_rd_data_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      up_q       <= 1'b0;
      inflight_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      up_q       <= 1'b1;
      inflight_q <= rd_fire;
      fwd_q      <= rd_fire & wr_fire & (wr_addr_i == rd_addr_i);
      fwd_data_q <= wr_data_i;
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  count_in_range: assert property (@(posedge clk_i) disable iff (!reset_ni) count_q <= 2'd2);

endmodule
